// File: rtl/dcache_dm.sv
// dcache_dm - direct-mapped, write-through, no-write-allocate data cache
// between the store/load buffer (SLB) and the memory controller (MC).
// One outstanding request at a time, tagged with the SLB nick.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register and the arrays
//   iFlush              invalidate all lines at the next edge
//   iSLB_*              request from the SLB (ls: 0=load 1=store, len in bytes)
//   oSLB_busy           high while a request is being processed
//   oSLB_done/dt/nick   one-cycle completion pulse with load data and tag
//   oMC_*               one-cycle request pulse to the memory controller
//   iMC_done/iMC_dt     MC completion pulse with read data
//
// Handshake: the SLB presents iSLB_en with its fields; the request is taken
// on the first rising edge (with rdy=1) where iSLB_en=1 and oSLB_busy=0.
// While oSLB_busy=1 iSLB_en is ignored and the SLB must keep holding it.
// iMC_done is only honoured while waiting on an MC transaction.
//
// The FSM state is kept in the typed signal `state` for probing.
module dcache_dm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NICK_W  = 4,
    parameter int LEN_W   = 3,
    parameter int INDEX_W = 6,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iFlush,
    input  logic              iSLB_en,
    input  logic              iSLB_ls,
    input  logic [ADDR_W-1:0] iSLB_pc,
    input  logic [DATA_W-1:0] iSLB_dt,
    input  logic [LEN_W-1:0]  iSLB_len,
    input  logic [NICK_W-1:0] iSLB_nick,
    output logic              oSLB_busy,
    output logic              oSLB_done,
    output logic [DATA_W-1:0] oSLB_dt,
    output logic [NICK_W-1:0] oSLB_nick,
    output logic              oMC_en,
    output logic              oMC_ls,
    output logic [ADDR_W-1:0] oMC_pc,
    output logic [DATA_W-1:0] oMC_dt,
    output logic [LEN_W-1:0]  oMC_len,
    input  logic              iMC_done,
    input  logic [DATA_W-1:0] iMC_dt
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t state, state_n;

    // Latched request
    logic              r_ls;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_dt;
    logic [LEN_W-1:0]  r_len;
    logic [NICK_W-1:0] r_nick;

    // Cache arrays
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];

    // Next values of the registered outputs and array write controls
    logic              slb_done_n, mc_en_n, mc_ls_n;
    logic [DATA_W-1:0] slb_dt_n, mc_dt_n, wr_data;
    logic [NICK_W-1:0] slb_nick_n;
    logic [ADDR_W-1:0] mc_pc_n;
    logic [LEN_W-1:0]  mc_len_n;
    logic              wr_line, fill;

    // Byte mask covering the low `len` bytes of a word.
    function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (b < int'(len)) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    logic [1:0]         off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [4:0]         sh;
    logic               cacheable, hit;
    logic [DATA_W-1:0]  line, mask;

    assign off       = r_pc[1:0];
    assign idx       = r_pc[INDEX_W+1:2];
    assign tag       = r_pc[ADDR_W-1:INDEX_W+2];
    assign sh        = {off, 3'b000};
    assign cacheable = r_pc < IO_BASE;
    assign line      = data_arr[idx];
    assign mask      = len_mask(r_len);
    // A flush in the lookup cycle invalidates the line, so it must miss.
    assign hit       = cacheable && valid[idx] && (tag_arr[idx] == tag) && !iFlush;

    // State register
    always_ff @(posedge clk) begin
        if (rst)      state <= S_IDLE;
        else if (rdy) state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (iSLB_en) state_n = S_LOOKUP;
            S_LOOKUP: state_n = (!r_ls && hit) ? S_IDLE : S_WAIT;
            S_WAIT:   if (iMC_done) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output logic: next values for the output registers and array writes.
    // Pulses default low; data/address outputs hold their last value.
    always_comb begin
        slb_done_n = 1'b0;
        slb_dt_n   = oSLB_dt;
        slb_nick_n = oSLB_nick;
        mc_en_n    = 1'b0;
        mc_ls_n    = oMC_ls;
        mc_pc_n    = oMC_pc;
        mc_dt_n    = oMC_dt;
        mc_len_n   = oMC_len;
        wr_line    = 1'b0;
        wr_data    = line;
        fill       = 1'b0;
        case (state)
            S_LOOKUP: begin
                if (!r_ls && hit) begin
                    slb_done_n = 1'b1;
                    slb_dt_n   = (line >> sh) & mask;
                    slb_nick_n = r_nick;
                end else begin
                    mc_en_n = 1'b1;
                    mc_ls_n = r_ls;
                    mc_dt_n = r_dt;
                    if (!r_ls && cacheable) begin
                        // Line fill: fetch the whole word
                        mc_pc_n  = {r_pc[ADDR_W-1:2], 2'b00};
                        mc_len_n = LEN_W'(4);
                    end else begin
                        mc_pc_n  = r_pc;
                        mc_len_n = r_len;
                    end
                    // Write-through: update the cached copy on a store hit
                    if (r_ls && hit) begin
                        wr_line = 1'b1;
                        wr_data = (line & ~(mask << sh)) | ((r_dt & mask) << sh);
                    end
                end
            end
            S_WAIT: begin
                if (iMC_done) begin
                    slb_done_n = 1'b1;
                    slb_nick_n = r_nick;
                    if (r_ls)           slb_dt_n = '0;
                    else if (cacheable) slb_dt_n = (iMC_dt >> sh) & mask;
                    else                slb_dt_n = iMC_dt & mask;
                    fill = !r_ls && cacheable && !iFlush;
                end
            end
            default: ;
        endcase
    end

    // Output, request-latch and valid-bit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            oSLB_busy <= 1'b0;
            oSLB_done <= 1'b0;
            oSLB_dt   <= '0;
            oSLB_nick <= '0;
            oMC_en    <= 1'b0;
            oMC_ls    <= 1'b0;
            oMC_pc    <= '0;
            oMC_dt    <= '0;
            oMC_len   <= '0;
            r_ls      <= 1'b0;
            r_pc      <= '0;
            r_dt      <= '0;
            r_len     <= '0;
            r_nick    <= '0;
            valid     <= '0;
        end else if (rdy) begin
            oSLB_busy <= (state_n != S_IDLE);
            oSLB_done <= slb_done_n;
            oSLB_dt   <= slb_dt_n;
            oSLB_nick <= slb_nick_n;
            oMC_en    <= mc_en_n;
            oMC_ls    <= mc_ls_n;
            oMC_pc    <= mc_pc_n;
            oMC_dt    <= mc_dt_n;
            oMC_len   <= mc_len_n;
            if (state == S_IDLE && iSLB_en) begin
                r_ls   <= iSLB_ls;
                r_pc   <= iSLB_pc;
                r_dt   <= iSLB_dt;
                r_len  <= iSLB_len;
                r_nick <= iSLB_nick;
            end
            if (iFlush)    valid      <= '0;
            else if (fill) valid[idx] <= 1'b1;
        end
    end

    // Data and tag arrays (not reset; guarded by the valid bits)
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (fill) begin
                data_arr[idx] <= iMC_dt;
                tag_arr[idx]  <= tag;
            end else if (wr_line) begin
                data_arr[idx] <= wr_data;
            end
        end
    end

endmodule
